wb_lsu_master: RTL and testbench

Wishbone initiator between the core's load/store stage and the byte-addressable data memory. It accepts one request at a time from the core and checks funct3 and alignment. It runs a single classic Wishbone cycle that forwards funct3 to the responder, then returns read data or an error to the core as a one-cycle response pulse. A watchdog ends any cycle the responder never acknowledges.

---
 rtl/wb_lsu_master.sv | 136 +++++++++++++
 tb/tb_wb_lsu_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_lsu_master.sv
// Wishbone initiator for the load/store stage: one request at a time, funct3/alignment
// checking, a single classic bus cycle with watchdog, and a one-cycle response pulse.
module wb_lsu_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 9,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [2:0]            wb_funct3_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                  state, state_next;
  logic [CW-1:0]           cnt, cnt_next;
  logic                    cyc, cyc_next;
  logic                    we_o_next;
  logic [ADDR_WIDTH-1:0]   adr_next;
  logic [DATA_WIDTH-1:0]   dat_next;
  logic [2:0]              f3_next;
  logic                    err_next;
  logic [DATA_WIDTH-1:0]   rdata_next;

  function automatic logic legal(input logic we, input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~a[0];
      3'b010:  ok = (a == 2'b00);
      3'b100:  ok = ~we;
      3'b101:  ok = ~we & ~a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cyc         <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_funct3_o <= '0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      cyc         <= cyc_next;
      wb_we_o     <= we_o_next;
      wb_adr_o    <= adr_next;
      wb_dat_o    <= dat_next;
      wb_funct3_o <= f3_next;
      resp_err    <= err_next;
      resp_rdata  <= rdata_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cyc_next   = 1'b0;
    we_o_next  = 1'b0;
    adr_next   = wb_adr_o;
    dat_next   = wb_dat_o;
    f3_next    = wb_funct3_o;
    err_next   = resp_err;
    rdata_next = resp_rdata;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (legal(req_we, req_funct3, req_addr[1:0])) begin
            state_next = BUS;
            cnt_next   = '0;
            cyc_next   = 1'b1;
            we_o_next  = req_we;
            adr_next   = req_addr;
            dat_next   = req_wdata;
            f3_next    = req_funct3;
          end else begin
            state_next = RESP;
            err_next   = 1'b1;
            rdata_next = '0;
          end
        end
      end
      BUS: begin
        // Ack wins over the watchdog even on its final cycle.
        if (wb_ack_i) begin
          state_next = RESP;
          err_next   = 1'b0;
          rdata_next = wb_we_o ? '0 : wb_dat_i;
        end else if (cnt == CNT_LAST) begin
          state_next = RESP;
          err_next   = 1'b1;
          rdata_next = '0;
        end else begin
          cnt_next  = cnt + 1'b1;
          cyc_next  = 1'b1;
          we_o_next = wb_we_o;
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign wb_cyc_o   = cyc;
  assign wb_stb_o   = cyc;

endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed bench for wb_lsu_master with a byte-addressed responder that does the
// sign/zero extension and acks one edge after it sees stb.
module tb_wb_lsu_master;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [2:0]    req_funct3 = '0;
  logic          resp_valid, resp_err;
  logic [DW-1:0] resp_rdata;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [2:0]    wb_funct3_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i;

  int checks = 0;
  int failures = 0;

  wb_lsu_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_funct3_o(wb_funct3_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  // Responder: registered ack (stays high one cycle after stb drops), extends read data.
  logic [7:0]  mem [0:511];
  logic        ack_q = 1'b0;
  logic        ack_en = 1'b1;
  logic        ack_force = 1'b0;
  logic [31:0] dat_q = '0;
  assign wb_ack_i = ack_q | ack_force;
  assign wb_dat_i = dat_q;

  function automatic logic [31:0] rd_ext(input logic [AW-1:0] a, input logic [2:0] f3);
    logic [AW-1:0] a1, a2, a3;
    logic [7:0]    b;
    logic [15:0]   h;
    a1 = a + 9'd1; a2 = a + 9'd2; a3 = a + 9'd3;
    b = mem[a];
    h = {mem[a1], mem[a]};
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return {mem[a3], mem[a2], mem[a1], mem[a]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (wb_cyc_o && wb_stb_o) begin
      ack_q <= ack_en;
      if (wb_we_o) begin
        mem[wb_adr_o] <= wb_dat_o[7:0];
        if (wb_funct3_o != 3'b000) mem[wb_adr_o + 9'd1] <= wb_dat_o[15:8];
        if (wb_funct3_o == 3'b010) begin
          mem[wb_adr_o + 9'd2] <= wb_dat_o[23:16];
          mem[wb_adr_o + 9'd3] <= wb_dat_o[31:24];
        end
      end else begin
        dat_q <= rd_ext(wb_adr_o, wb_funct3_o);
      end
    end else begin
      ack_q <= 1'b0;
    end
  end

  // Issues one request and watches until its response (bounded); cycle k counts from acceptance.
  task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input int force_cycle,
                        output int lat, output int cyc_cnt, output logic err,
                        output logic [31:0] rdata, output logic [2:0] f3_seen);
    lat = 0; cyc_cnt = 0; err = 1'b0; rdata = '0; f3_seen = '0;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      ack_force = (k == force_cycle);
      if (wb_cyc_o) begin
        cyc_cnt++;
        f3_seen = wb_funct3_o;
      end
      if (resp_valid) begin
        lat = k; err = resp_err; rdata = resp_rdata;
        break;
      end
    end
    ack_force = 1'b0;
    $display("txn we=%0b addr=%03h f3=%03b -> lat=%0d cyc=%0d err=%0b rdata=%08h",
             we, addr, f3, lat, cyc_cnt, err, rdata);
  endtask

  task automatic test_reset;
    #2;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_resp got v=%b e=%b d=%h exp 0/0/0", resp_valid, resp_err, resp_rdata); end
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0) begin
      failures++; $display("FAIL reset_bus got cyc=%b stb=%b we=%b exp 0", wb_cyc_o, wb_stb_o, wb_we_o); end
    checks++; if (wb_adr_o !== '0 || wb_dat_o !== '0 || wb_funct3_o !== '0) begin
      failures++; $display("FAIL reset_regs got adr=%h dat=%h f3=%b exp 0", wb_adr_o, wb_dat_o, wb_funct3_o); end
    $display("reset checked");
    @(negedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic test_word;
    int lat, cc; logic err; logic [31:0] rd; logic [2:0] f3s;
    do_txn(1'b1, 9'h010, 32'hDEADBEEF, 3'b010, 0, lat, cc, err, rd, f3s);
    checks++; if (cc != 2) begin failures++; $display("FAIL sw_cyc_cycles got=%0d exp=2", cc); end
    checks++; if (f3s !== 3'b010) begin failures++; $display("FAIL sw_funct3 got=%b exp=010", f3s); end
    checks++; if (lat != 3 || err !== 1'b0 || rd !== 32'h0) begin
      failures++; $display("FAIL sw_resp got lat=%0d err=%b rd=%h exp 3/0/0", lat, err, rd); end
    do_txn(1'b0, 9'h010, 32'h0, 3'b010, 0, lat, cc, err, rd, f3s);
    checks++; if (lat != 3 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL lw_resp got lat=%0d err=%b rd=%h exp 3/0/deadbeef", lat, err, rd); end
  endtask

  task automatic test_subword;
    logic [AW-1:0] a [4];
    logic [2:0]    f [4];
    logic [31:0]   e [4];
    int lat, cc; logic err; logic [31:0] rd; logic [2:0] f3s;
    a = '{9'h013, 9'h013, 9'h012, 9'h010};
    f = '{3'b000, 3'b100, 3'b101, 3'b001};
    e = '{32'hFFFFFFDE, 32'h000000DE, 32'h0000DEAD, 32'hFFFFBEEF};
    for (int i = 0; i < 4; i++) begin
      do_txn(1'b0, a[i], 32'h0, f[i], 0, lat, cc, err, rd, f3s);
      checks++; if (lat != 3 || err !== 1'b0 || rd !== e[i]) begin
        failures++; $display("FAIL subword_%0d got lat=%0d err=%b rd=%h exp 3/0/%h", i, lat, err, rd, e[i]); end
    end
  endtask

  task automatic test_illegal;
    logic          w [3];
    logic [AW-1:0] a [3];
    logic [2:0]    f [3];
    int lat, cc; logic err; logic [31:0] rd; logic [2:0] f3s;
    w = '{1'b0, 1'b1, 1'b1};
    a = '{9'h011, 9'h001, 9'h020};
    f = '{3'b010, 3'b001, 3'b100};
    for (int i = 0; i < 3; i++) begin
      do_txn(w[i], a[i], 32'h5A5A5A5A, f[i], 0, lat, cc, err, rd, f3s);
      checks++; if (lat != 1 || err !== 1'b1 || rd !== 32'h0 || cc != 0) begin
        failures++; $display("FAIL illegal_%0d got lat=%0d err=%b rd=%h cyc=%0d exp 1/1/0/0", i, lat, err, rd, cc); end
    end
  endtask

  task automatic test_timeout;
    int lat, cc; logic err; logic [31:0] rd; logic [2:0] f3s;
    ack_en = 1'b0;
    do_txn(1'b0, 9'h010, 32'h0, 3'b010, 0, lat, cc, err, rd, f3s);
    checks++; if (cc != TO || lat != TO + 1 || err !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("FAIL timeout got cyc=%0d lat=%0d err=%b rd=%h exp 16/17/1/0", cc, lat, err, rd); end
    checks++; if (wb_cyc_o !== 1'b0) begin failures++; $display("FAIL timeout_cyc_low got=%b exp=0", wb_cyc_o); end
    // Ack arriving on the final watchdog cycle must still count as success.
    do_txn(1'b0, 9'h010, 32'h0, 3'b010, TO, lat, cc, err, rd, f3s);
    checks++; if (lat != TO + 1 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL ack_last got lat=%0d err=%b rd=%h exp 17/0/deadbeef", lat, err, rd); end
    ack_en = 1'b1;
  endtask

  task automatic test_ack_inject;
    int seen = 0;
    @(negedge clk);
    ack_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid || wb_cyc_o || !req_ready) seen++;
    end
    ack_force = 1'b0;
    checks++; if (seen != 0) begin failures++; $display("FAIL idle_ack got events=%0d exp=0", seen); end
    $display("idle ack injection events=%0d", seen);
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] a [4];
    logic [2:0]    f [4];
    logic [31:0]   e [4];
    int acc = 0, nresp = 0, last_resp = 0, cyc_low = 0;
    logic accepting;
    a = '{9'h010, 9'h013, 9'h012, 9'h011};
    f = '{3'b010, 3'b100, 3'b101, 3'b100};
    e = '{32'hDEADBEEF, 32'h000000DE, 32'h0000DEAD, 32'h000000BE};
    @(negedge clk);
    req_we = 1'b0; req_addr = a[0]; req_funct3 = f[0]; req_valid = 1'b1;
    for (int c = 0; c < 60 && nresp < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (resp_valid) begin
        $display("b2b resp %0d cycle=%0d rdata=%08h err=%0b", nresp, c, resp_rdata, resp_err);
        checks++; if (resp_rdata !== e[nresp] || resp_err !== 1'b0) begin
          failures++; $display("FAIL b2b_data_%0d got=%h err=%b exp=%h", nresp, resp_rdata, resp_err, e[nresp]); end
        if (nresp > 0) begin
          checks++; if (c - last_resp != 4 || cyc_low < 1) begin
            failures++; $display("FAIL b2b_spacing_%0d got=%0d gap=%0d exp=4 gap>=1", nresp, c - last_resp, cyc_low); end
        end
        last_resp = c; cyc_low = 0; nresp++;
      end else if (!wb_cyc_o) begin
        cyc_low++;
      end
      accepting = req_ready && req_valid;
      @(posedge clk);
      #1;
      if (accepting) begin
        acc++;
        if (acc < 4) begin req_addr = a[acc]; req_funct3 = f[acc]; end
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++; if (nresp != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", nresp); end
  endtask

  task automatic test_async_reset;
    int seen = 0;
    ack_en = 1'b0;
    @(negedge clk);
    req_we = 1'b1; req_addr = 9'h040; req_wdata = 32'h12345678; req_funct3 = 3'b010; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b1) begin
      failures++; $display("FAIL rst_pre_bus got cyc=%b we=%b exp 1/1", wb_cyc_o, wb_we_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_we_o !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL rst_async got cyc=%b stb=%b we=%b rdy=%b exp 0/0/0/1",
                           wb_cyc_o, wb_stb_o, wb_we_o, req_ready); end
    #1 rst_n = 1'b1;
    ack_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid || wb_cyc_o) seen++;
    end
    checks++; if (seen != 0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL rst_after got events=%0d rdy=%b exp 0/1", seen, req_ready); end
    $display("async reset: post-release events=%0d ready=%0b", seen, req_ready);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    test_reset();
    test_word();
    test_subword();
    test_illegal();
    test_timeout();
    test_ack_inject();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end
endmodule
